// File: rtl/rechenwerk_pkg.sv
// Shared definitions for the sequential arithmetic unit: op encodings, FSM states and
// the counter-width helper.
package rechenwerk_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    // Ceiling log2; clog2(WIDTH + 1) bits hold a step counter loaded with WIDTH.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/ripple_addierer.sv
// WIDTH-bit ripple-carry adder, one full-adder cell per bit, with carry-in and carry-out.
module ripple_addierer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    logic [WIDTH:0] carry;

    assign carry[0] = carry_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign carry_out = carry[WIDTH];

endmodule

// File: rtl/seq_rechenwerk.sv
// Sequential ADD/SUB/MUL unit with valid/ready handshakes, sharing one ripple adder.
// Define RECHENWERK_DIVIDE_EN to add restoring unsigned division on op 11.
module seq_rechenwerk
    import rechenwerk_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               in_clk,
    input  logic               in_reset,
    input  logic               in_valid,
    output logic               out_ready,
    input  logic [1:0]         in_op,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               in_res_ready,
    output logic [2*WIDTH-1:0] out_result,
    output logic               out_carry,
    output logic               out_error,
    output logic               out_busy
);

    localparam int unsigned CNT_W = clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               carry_q, carry_d;
    logic               error_q, error_d;

    logic [WIDTH-1:0]   add_x, add_y, add_sum;
    logic               add_cin, add_cout;
    logic [WIDTH-1:0]   acc_hi, acc_lo;

    assign acc_hi = acc_q[2*WIDTH-1:WIDTH];
    assign acc_lo = acc_q[WIDTH-1:0];

`ifdef RECHENWERK_DIVIDE_EN
    // Partial remainder shifted left with the next dividend bit; it may briefly need WIDTH+1 bits.
    logic [WIDTH:0] div_tmp;
    logic           div_ge;

    assign div_tmp = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge  = div_tmp[WIDTH] | add_cout;
`endif

    ripple_addierer #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a         (add_x),
        .b         (add_y),
        .carry_in  (add_cin),
        .sum       (add_sum),
        .carry_out (add_cout)
    );

    always_comb begin
        add_x   = in_a;
        add_y   = in_b;
        add_cin = 1'b0;
        if (state_q == IDLE) begin
            if (in_op == OP_SUB) begin
                add_y   = ~in_b;
                add_cin = 1'b1;
            end
        end else if (op_q == OP_MUL) begin
            add_x = acc_hi;
            add_y = b_q & {WIDTH{acc_lo[0]}};
        end
`ifdef RECHENWERK_DIVIDE_EN
        else begin
            add_x   = div_tmp[WIDTH-1:0];
            add_y   = ~b_q;
            add_cin = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        error_d = error_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = in_op;
                    b_d     = in_b;
                    acc_d   = '0;
                    carry_d = 1'b0;
                    error_d = 1'b0;
                    unique case (in_op)
                        OP_ADD: begin
                            acc_d   = {{WIDTH{1'b0}}, add_sum};
                            carry_d = add_cout;
                            state_d = DONE;
                        end
                        OP_SUB: begin
                            acc_d   = {{WIDTH{1'b0}}, add_sum};
                            carry_d = ~add_cout;
                            state_d = DONE;
                        end
                        OP_MUL: begin
                            acc_d   = {{WIDTH{1'b0}}, in_a};
                            cnt_d   = CNT_W'(WIDTH);
                            state_d = CALC;
                        end
                        default: begin
`ifdef RECHENWERK_DIVIDE_EN
                            acc_d   = {{WIDTH{1'b0}}, in_a};
                            error_d = (in_b == '0);
                            cnt_d   = CNT_W'(WIDTH);
                            state_d = CALC;
`else
                            error_d = 1'b1;
                            state_d = DONE;
`endif
                        end
                    endcase
                end
            end
            CALC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (op_q == OP_MUL) begin
                    // {carry, acc_hi + b*a[i], acc_lo} shifted right by one.
                    acc_d = {add_cout, add_sum, acc_lo[WIDTH-1:1]};
                end
`ifdef RECHENWERK_DIVIDE_EN
                else begin
                    acc_d = {(div_ge ? add_sum : div_tmp[WIDTH-1:0]), acc_lo[WIDTH-2:0], div_ge};
                end
`endif
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (in_res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_ADD;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            error_q <= error_d;
        end
    end

    // Partial products and remainders are kept off the result bus until DONE.
    assign out_ready  = (state_q == IDLE);
    assign out_busy   = (state_q != IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_result = (state_q == DONE) ? acc_q : '0;
    assign out_carry  = (state_q == DONE) ? carry_q : 1'b0;
    assign out_error  = (state_q == DONE) ? error_q : 1'b0;

endmodule

// File: tb/tb_seq_rechenwerk.sv
// Randomised and directed bench for seq_rechenwerk against a latency/arithmetic model.
module tb_seq_rechenwerk;
    import rechenwerk_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  in_op = 2'b00;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic        in_res_ready = 1'b0;
    logic        out_ready, out_valid, out_carry, out_error, out_busy;
    logic [15:0] out_result;

    logic        v16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        rr16 = 1'b0;
    logic        ready16, valid16, carry16, error16, busy16;
    logic [31:0] result16;

    int checks = 0;
    int failures = 0;

    // Model state: busy, valid and cycles still to wait before valid.
    logic        m_busy = 1'b0;
    logic        m_valid = 1'b0;
    int          m_wait = 0;
    logic [15:0] m_res = '0;
    logic        m_carry = 1'b0;
    logic        m_err = 1'b0;

    always #5 clk = ~clk;

    seq_rechenwerk #(.WIDTH(8)) dut (
        .in_clk       (clk),
        .in_reset     (rst),
        .in_valid     (in_valid),
        .out_ready    (out_ready),
        .in_op        (in_op),
        .in_a         (in_a),
        .in_b         (in_b),
        .out_valid    (out_valid),
        .in_res_ready (in_res_ready),
        .out_result   (out_result),
        .out_carry    (out_carry),
        .out_error    (out_error),
        .out_busy     (out_busy)
    );

    seq_rechenwerk #(.WIDTH(16)) dut16 (
        .in_clk       (clk),
        .in_reset     (rst),
        .in_valid     (v16),
        .out_ready    (ready16),
        .in_op        (OP_MUL),
        .in_a         (a16),
        .in_b         (b16),
        .out_valid    (valid16),
        .in_res_ready (rr16),
        .out_result   (result16),
        .out_carry    (carry16),
        .out_error    (error16),
        .out_busy     (busy16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [15:0] r, output logic c, output logic e,
                                  output int lat);
        int unsigned ai = a;
        int unsigned bi = b;
        r = '0;
        c = 1'b0;
        e = 1'b0;
        lat = 1;
        case (op)
            OP_ADD: begin
                r = 16'((ai + bi) % 256);
                c = (ai + bi) > 255;
            end
            OP_SUB: begin
                r = 16'((ai + 256 - bi) % 256);
                c = ai < bi;
            end
            OP_MUL: begin
                r = 16'(ai * bi);
                lat = 9;
            end
            default: begin
`ifdef RECHENWERK_DIVIDE_EN
                lat = 9;
                if (bi == 0) begin
                    r = {a, 8'hFF};
                    e = 1'b1;
                end else begin
                    r = 16'((ai % bi) * 256 + ai / bi);
                end
`else
                e = 1'b1;
`endif
            end
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        int lat;
        if (rst) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_wait  = 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                model(in_op, in_a, in_b, m_res, m_carry, m_err, lat);
                m_busy  = 1'b1;
                m_wait  = lat - 1;
                m_valid = (lat == 1);
            end
        end else if (!m_valid) begin
            m_wait--;
            if (m_wait == 0) m_valid = 1'b1;
        end else if (in_res_ready) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("m_ready", 32'(out_ready), 32'(!m_busy));
            check("m_busy", 32'(out_busy), 32'(m_busy));
            check("m_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                check("m_result", 32'(out_result), 32'(m_res));
                check("m_carry", 32'(out_carry), 32'(m_carry));
                check("m_error", 32'(out_error), 32'(m_err));
            end
        end
    end

    task automatic run(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] er, input logic ec, input logic ee,
                       input int ecyc, input int hold);
        int c;
        logic [15:0] snap;
        @(negedge clk);
        in_op = op;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        in_res_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        c = 1;
        while (!out_valid && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("latency", 32'(c), 32'(ecyc));
        check("result", 32'(out_result), 32'(er));
        check("carry", 32'(out_carry), 32'(ec));
        check("error", 32'(out_error), 32'(ee));
        snap = out_result;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_op = OP_ADD;
            in_a = 8'($urandom);
            @(negedge clk);
            check("hold_result", 32'(out_result), 32'(snap));
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_ready", 32'(out_ready), 32'd0);
        end
        in_valid = 1'b0;
        in_res_ready = 1'b1;
        @(negedge clk);
        in_res_ready = 1'b0;
        check("idle_after", 32'(out_ready), 32'd1);
    endtask

    function automatic logic [7:0] pick();
        int unsigned s = $urandom_range(0, 7);
        if (s == 0) return 8'h00;
        if (s == 1) return 8'hFF;
        return 8'($urandom);
    endfunction

    initial begin
        int c;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(out_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(out_result), 32'd0);
        check("rst_busy", 32'(out_busy), 32'd0);
        rst = 1'b0;

        run(OP_ADD, 8'd200, 8'd100, 16'h002C, 1'b1, 1'b0, 1, 0);
        run(OP_SUB, 8'd5, 8'd7, 16'h00FE, 1'b1, 1'b0, 1, 0);
        run(OP_SUB, 8'd7, 8'd5, 16'h0002, 1'b0, 1'b0, 1, 0);
        run(OP_MUL, 8'd255, 8'd255, 16'hFE01, 1'b0, 1'b0, 9, 0);
        run(OP_MUL, 8'd0, 8'd123, 16'h0000, 1'b0, 1'b0, 9, 0);
        run(OP_MUL, 8'd13, 8'd11, 16'h008F, 1'b0, 1'b0, 9, 5);
`ifdef RECHENWERK_DIVIDE_EN
        run(OP_DIV, 8'd200, 8'd7, 16'h041C, 1'b0, 1'b0, 9, 0);
        run(OP_DIV, 8'd9, 8'd0, 16'h09FF, 1'b0, 1'b1, 9, 0);
`else
        run(OP_DIV, 8'd200, 8'd7, 16'h0000, 1'b0, 1'b1, 1, 0);
`endif

        // Reset in cycle 4 of a multiply, then a clean add.
        @(negedge clk);
        in_op = OP_MUL;
        in_a = 8'd200;
        in_b = 8'd3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(out_ready), 32'd1);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_result", 32'(out_result), 32'd0);
        check("mid_rst_carry", 32'(out_carry), 32'd0);
        check("mid_rst_error", 32'(out_error), 32'd0);
        check("mid_rst_busy", 32'(out_busy), 32'd0);
        #1 rst = 1'b0;
        run(OP_ADD, 8'd1, 8'd1, 16'h0002, 1'b0, 1'b0, 1, 0);

        // Wide multiply on the WIDTH=16 instance.
        @(negedge clk);
        a16 = 16'hFFFF;
        b16 = 16'hFFFF;
        v16 = 1'b1;
        @(negedge clk);
        v16 = 1'b0;
        c = 1;
        while (!valid16 && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("w16_latency", 32'(c), 32'd17);
        check("w16_result", result16, 32'hFFFE0001);
        check("w16_carry", 32'(carry16), 32'd0);
        rr16 = 1'b1;
        @(negedge clk);
        rr16 = 1'b0;
        check("w16_idle", 32'(ready16), 32'd1);

        // Random traffic with random backpressure and occasional mid-flight resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 1) == 1);
            in_op = 2'($urandom_range(0, 3));
            in_a = pick();
            in_b = pick();
            in_res_ready = ($urandom_range(0, 3) != 0);
            if (i % 700 == 350) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_rechenwerk.md
Name: seq_rechenwerk

Overview:
- Parametrised sequential arithmetic unit and successor to the 8-bit combinational adder/multiplier set.
- Performs ADD, SUB, and unsigned MUL (shift-add, one partial product per cycle); DIV is optional.
- Uses a valid/ready handshake on both sides and sits between register file and result bus in the datapath.
- Reuses the full-adder cell as a ripple adder of WIDTH bits.

Parameters:
- WIDTH, 8, operand width in bits (>= 2); result width is 2*WIDTH.

Ports:
- in_clk  input  1  clock; all state updates on rising edge.
- in_reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- out_ready  output  1  unit can accept a request (high only in IDLE).
- in_op  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV.
- in_a  input  WIDTH  operand A (unsigned).
- in_b  input  WIDTH  operand B (unsigned).
- out_valid  output  1  result valid; held until consumed.
- in_res_ready  input  1  consumer takes result.
- out_result  output  2*WIDTH  result.
- out_carry  output  1  ADD carry-out / SUB borrow; 0 for MUL/DIV.
- out_error  output  1  DIV by zero or unsupported op.
- out_busy  output  1  state != IDLE.

Behaviour:
- Interface as decided: one clock, in_clk; reset in_reset is asynchronous and active-high.
- Reset values: state IDLE, out_ready 1, out_valid 0, out_result 0, out_carry 0, out_error 0, out_busy 0, counter 0.
- Accept occurs when in_valid && out_ready at a rising edge ("edge k"). Operands and op are latched. Inputs are ignored outside IDLE.
- States:
  - IDLE: on accept, ADD/SUB/unsupported op -> DONE; MUL/DIV -> CALC with counter = WIDTH.
  - CALC: one step per cycle, counter decrements. When counter == 1, go to DONE at that edge.
  - DONE: out_valid = 1, outputs stable. When in_res_ready = 1, go to IDLE at that edge. There is no accept in the same cycle.
- Latency, counting the cycle after edge k as cycle 1:
  - ADD/SUB: out_valid in cycle 1.
  - MUL/DIV: out_valid in cycle WIDTH+1.
  - Throughput: one request per (latency + 1) cycles minimum.
- ADD: out_result = {WIDTH'0, (a+b) mod 2^WIDTH}; out_carry = carry-out.
- SUB: out_result = {WIDTH'0, (a-b) mod 2^WIDTH}; out_carry = 1 iff a < b (borrow).
- MUL: unsigned 2*WIDTH product, LSB-first shift-add.
  - Accumulator is {carry, acc_hi, acc_lo}. Each step adds b·a[i] to acc_hi, then shifts right one bit.
  - No truncation. Max value is (2^W-1)^2.
- Backpressure: DONE holds indefinitely; outputs must not change while out_valid && !in_res_ready.
- Reset mid-operation: immediate return to reset values. The partial result is discarded and never presented.
- in_valid asserted while busy: no effect, no queuing.

Optional Feature:
- Macro: RECHENWERK_DIVIDE_EN.
- Defined: op 11 performs restoring unsigned division in WIDTH CALC steps.
  - out_result = {remainder, quotient}, out_error = 0.
  - b == 0: quotient all ones, remainder = a, out_error = 1, latency still WIDTH+1.
- Undefined: op 11 goes directly to DONE (latency 1) with out_result 0, out_carry 0, out_error 1. No divider logic is synthesised.

Decomposition:
- Package rechenwerk_pkg holds:
  - op encodings OP_ADD/OP_SUB/OP_MUL/OP_DIV (2-bit);
  - state enum IDLE/CALC/DONE;
  - counter-width function clog2(WIDTH+1).
- One sub-module, ripple_addierer: parametrised WIDTH ripple-carry adder with carry-in and carry-out, built from the full-adder cell.
  - Shared by ADD, SUB (b inverted, carry-in 1, borrow = ~carry-out), MUL accumulate, and DIV trial subtract.

Test Plan:
- WIDTH=8, ADD 200+100 -> out_result 0x002C, out_carry 1, out_valid in cycle 1.
- SUB 5-7 -> out_result 0x00FE, out_carry 1; SUB 7-5 -> 0x0002, out_carry 0.
- MUL 255*255 -> 0xFE01 with out_valid first high in cycle 9. MUL 0*123 -> 0x0000. Repeat with WIDTH=16: 0xFFFF*0xFFFF -> 0xFFFE0001 in cycle 17.
- MUL 13*11 with in_res_ready low for 5 cycles -> 0x008F held stable, out_ready 0, new in_valid ignored; IDLE one cycle after in_res_ready.
- in_reset pulsed in cycle 4 of MUL 200*3 -> all outputs at reset values immediately; a following ADD 1+1 -> 0x0002 correct.
- With RECHENWERK_DIVIDE_EN: DIV 200/7 -> 0x041C, out_error 0, cycle 9; DIV 9/0 -> 0x09FF, out_error 1. Without the macro: DIV 200/7 -> 0x0000, out_error 1, cycle 1.
